// File: rtl/rom_seq_reader.sv
// rom_seq_reader: walks the one-hot ROM words in order and streams each captured byte with a running checksum
module rom_seq_reader #(
  parameter int NUM_WORDS = 8,
  parameter int DATA_W    = 8,
  parameter int READ_LAT  = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_rom_en,
  output logic [7:0]        o_rom_addr,
  input  logic [DATA_W-1:0] i_rom_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_checksum,
  output logic [2:0]        o_idx
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HOLD, DONE} state_t;
  state_t state, nxt;
  logic [2:0] lat_cnt, idx_nxt;
  logic lat_done;
  assign lat_done = lat_cnt == 3'(READ_LAT - 1);
  assign o_busy   = state != IDLE;
  assign o_done   = state == DONE;
  assign o_valid  = state == HOLD;
  always_comb begin
    nxt = state;
    idx_nxt = o_idx;
    case (state)
      IDLE: if (i_start) begin
        nxt = ISSUE;
        idx_nxt = '0;
      end
      ISSUE: nxt = WAIT;
      WAIT: nxt = lat_done ? HOLD : WAIT;
      HOLD: if (i_ready) begin
        nxt = (o_idx == 3'(NUM_WORDS - 1)) ? DONE : ISSUE;
        idx_nxt = (o_idx == 3'(NUM_WORDS - 1)) ? o_idx : o_idx + 3'd1;
      end
      default: nxt = IDLE;
    endcase
  end
  // ROM strobes are registered from the next state so they rise together with ISSUE
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      o_idx      <= '0;
      lat_cnt    <= '0;
      o_rom_en   <= 1'b0;
      o_rom_addr <= '0;
      o_data     <= '0;
      o_checksum <= '0;
    end else begin
      state      <= nxt;
      o_idx      <= idx_nxt;
      lat_cnt    <= (state == WAIT && !lat_done) ? lat_cnt + 3'd1 : 3'd0;
      o_rom_en   <= nxt == ISSUE;
      o_rom_addr <= (nxt == ISSUE) ? 8'(1) << idx_nxt : 8'd0;
      if (state == IDLE && i_start)
        o_checksum <= '0;
      if (state == WAIT && lat_done) begin
        o_data     <= i_rom_data;
        o_checksum <= o_checksum + i_rom_data;
      end
    end
  end
endmodule

// File: tb/tb_rom_seq_reader.sv
// tb_rom_seq_reader: directed runs against a registered ROM model, with protocol monitoring
module tb_rom_seq_reader;
  logic i_clk = 0, i_rst_n = 0;
  logic start0 = 0, ready0 = 1, start1 = 0, ready1 = 1;
  logic busy0, done0, en0, valid0, busy1, done1, en1, valid1;
  logic [7:0] addr0, data0, sum0, rd0, addr1, data1, sum1, q1, q2, q3;
  logic [2:0] idx0, idx1;
  logic [7:0] rom [8];
  int total = 0, bad = 0;

  always #5 i_clk = ~i_clk;

  rom_seq_reader u0 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(start0), .o_busy(busy0), .o_done(done0),
    .o_rom_en(en0), .o_rom_addr(addr0), .i_rom_data(rd0), .o_data(data0), .o_valid(valid0),
    .i_ready(ready0), .o_checksum(sum0), .o_idx(idx0));

  rom_seq_reader #(.NUM_WORDS(4), .DATA_W(8), .READ_LAT(3)) u1 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(start1), .o_busy(busy1), .o_done(done1),
    .o_rom_en(en1), .o_rom_addr(addr1), .i_rom_data(q3), .o_data(data1), .o_valid(valid1),
    .i_ready(ready1), .o_checksum(sum1), .o_idx(idx1));

  function automatic int oh(input logic [7:0] a);
    int r = 0;
    for (int i = 0; i < 8; i++) if (a[i]) r = i;
    return r;
  endfunction

  always @(posedge i_clk) begin
    if (en0) rd0 <= rom[oh(addr0)];
    if (en1) q1 <= rom[oh(addr1)];
    q2 <= q1;
    q3 <= q2;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  logic pe0 = 0, pv0 = 0, pe1 = 0, pv1 = 0;
  logic [7:0] pd0 = 0, pd1 = 0;
  always @(posedge i_clk) begin
    #1;
    if (i_rst_n) begin
      check("p_en2_0", {31'd0, pe0 & en0}, 0);
      check("p_addr0", {24'd0, addr0}, en0 ? 32'(1) << oh(addr0) : 0);
      check("p_oh0", {31'd0, en0 ? $onehot(addr0) : 1'b1}, 1);
      if (pv0 && !ready0 && valid0) check("p_hold0", {24'd0, data0}, {24'd0, pd0});
      check("p_en2_1", {31'd0, pe1 & en1}, 0);
      check("p_addr1", {24'd0, addr1}, en1 ? 32'(1) << oh(addr1) : 0);
      check("p_oh1", {31'd0, en1 ? $onehot(addr1) : 1'b1}, 1);
      if (pv1 && !ready1 && valid1) check("p_hold1", {24'd0, data1}, {24'd0, pd1});
    end
    pe0 = en0; pv0 = valid0; pd0 = data0;
    pe1 = en1; pv1 = valid1; pd1 = data1;
  end

  task automatic chk_zero0(input string tag);
    check({tag, "_busy"}, {31'd0, busy0}, 0);
    check({tag, "_done"}, {31'd0, done0}, 0);
    check({tag, "_en"}, {31'd0, en0}, 0);
    check({tag, "_addr"}, {24'd0, addr0}, 0);
    check({tag, "_data"}, {24'd0, data0}, 0);
    check({tag, "_valid"}, {31'd0, valid0}, 0);
    check({tag, "_sum"}, {24'd0, sum0}, 0);
    check({tag, "_idx"}, {29'd0, idx0}, 0);
  endtask

  // bp: stall cycles on word 2; restart: extra start pulse in cycle 10; rst_at: reset cycle (0 = none)
  task automatic run0(input int bp, input bit restart, input int rst_at);
    int b;
    logic e, v;
    @(negedge i_clk);
    start0 = 1;
    for (int c = 1; c <= 26 + bp; c++) begin
      @(negedge i_clk);
      start0 = (c == 1) ? 1'b0 : (restart && c == 10);
      ready0 = !(bp > 0 && c >= 9 && c <= 8 + bp);
      if (c == rst_at) begin
        i_rst_n = 0;
        #1;
        chk_zero0("rst_mid");
        return;
      end
      if (bp > 0 && c >= 9 && c <= 9 + bp) begin
        check("bp_valid", {31'd0, valid0}, 1);
        check("bp_data", {24'd0, data0}, 32'h44);
        check("bp_en", {31'd0, en0}, 0);
        continue;
      end
      b = (c > 9 + bp) ? c - bp : c;
      e = b <= 22 && (b - 1) % 3 == 0;
      v = b >= 3 && b <= 24 && b % 3 == 0;
      check("en", {31'd0, en0}, {31'd0, e});
      check("addr", {24'd0, addr0}, e ? 32'(1) << ((b - 1) / 3) : 0);
      check("valid", {31'd0, valid0}, {31'd0, v});
      check("busy", {31'd0, busy0}, {31'd0, b >= 1 && b <= 25});
      check("done", {31'd0, done0}, {31'd0, b == 25});
      if (v) begin
        check("data", {24'd0, data0}, {24'd0, rom[(b - 3) / 3]});
        check("idx", {29'd0, idx0}, (b - 3) / 3);
      end
      if (b == 3) check("sum_first", {24'd0, sum0}, 32'h48);
    end
    check("sum_final", {24'd0, sum0}, 32'hE3);
    check("busy_idle", {31'd0, busy0}, 0);
  endtask

  task automatic run1();
    logic e, v;
    @(negedge i_clk);
    start1 = 1;
    for (int c = 1; c <= 22; c++) begin
      @(negedge i_clk);
      start1 = 0;
      e = c <= 16 && (c - 1) % 5 == 0;
      v = c >= 5 && c <= 20 && c % 5 == 0;
      check("l3_en", {31'd0, en1}, {31'd0, e});
      check("l3_addr", {24'd0, addr1}, e ? 32'(1) << ((c - 1) / 5) : 0);
      check("l3_valid", {31'd0, valid1}, {31'd0, v});
      check("l3_busy", {31'd0, busy1}, {31'd0, c <= 21});
      check("l3_done", {31'd0, done1}, {31'd0, c == 21});
      if (v) check("l3_data", {24'd0, data1}, {24'd0, rom[c / 5 - 1]});
    end
    check("l3_sum", {24'd0, sum1}, 32'h96);
  endtask

  initial begin
    rom[0] = 8'h48; rom[1] = 8'h67; rom[2] = 8'h44; rom[3] = 8'hA3;
    rom[4] = 8'hBB; rom[5] = 8'hDE; rom[6] = 8'hAD; rom[7] = 8'h07;
    rd0 = 0; q1 = 0; q2 = 0; q3 = 0;
    repeat (2) @(negedge i_clk);
    chk_zero0("rst");
    i_rst_n = 1;
    repeat (2) @(negedge i_clk);
    run0(0, 0, 0);
    run0(5, 0, 0);
    run0(0, 1, 0);
    run0(0, 0, 12);
    @(negedge i_clk);
    i_rst_n = 1;
    @(negedge i_clk);
    check("sum_after_rst", {24'd0, sum0}, 0);
    run0(0, 0, 0);
    run1();
    repeat (3) @(negedge i_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule

// File: doc/rom_seq_reader.md
Name: rom_seq_reader

Overview:
- Read initiator for the one-hot-addressed byte ROM controller.
- On a start pulse, walks word indices 0..NUM_WORDS-1 and drives the one-hot address (1<<idx) with a single-cycle enable.
- Captures each returned byte after the ROM's registered read latency and presents it on a valid/ready output stream.
- Accumulates a mod-2^DATA_W checksum of all bytes read; feeds downstream display/compare logic.

Parameters:
- NUM_WORDS, 8, number of ROM words read per run (1..8; must fit the one-hot address width).
- DATA_W, 8, ROM data, stream and checksum width.
- READ_LAT, 1, cycles from the ROM sampling o_rom_en/o_rom_addr to i_rom_data being valid (1..4).

Ports:
- i_clk  in  1  clock, all state on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  start a read run; sampled only in IDLE.
- o_busy  out  1  high whenever state != IDLE.
- o_done  out  1  one-cycle pulse after the last word is transferred.
- o_rom_en  out  1  ROM read enable, registered.
- o_rom_addr  out  8  one-hot ROM address, registered; 0 when o_rom_en=0.
- i_rom_data  in  DATA_W  ROM read data.
- o_data  out  DATA_W  captured word; stable while o_valid=1.
- o_valid  out  1  stream valid.
- i_ready  in  1  stream ready from consumer.
- o_checksum  out  DATA_W  running sum of captured words mod 2^DATA_W.
- o_idx  out  3  index of the word currently in flight.

Behaviour:
- Reset, asynchronous on i_rst_n=0, overrides everything, including mid-run: state IDLE; every output 0 (o_busy, o_done, o_rom_en, o_rom_addr, o_data, o_valid, o_checksum, o_idx); latency counter 0.
- After reset release, the block waits for a new i_start. A run aborted by reset is not resumed.
- FSM states:
  - IDLE: i_start=1 -> ISSUE; clear idx and checksum.
  - ISSUE: one cycle; o_rom_en=1, o_rom_addr=1<<idx. -> WAIT.
  - WAIT: o_rom_en=0, o_rom_addr=0. Count READ_LAT cycles. At the end of the last WAIT cycle, capture i_rom_data into o_data, add it to o_checksum (wrap mod 2^DATA_W), and go to HOLD.
  - HOLD: o_valid=1, o_data held.
    - i_ready=1 transfers the word: if idx==NUM_WORDS-1 -> DONE, else idx+1 and -> ISSUE.
    - i_ready=0 stays in HOLD indefinitely, with o_data and o_checksum unchanged.
  - DONE: one cycle; o_done=1, o_valid=0. -> IDLE.
- o_rom_en is high for exactly one cycle per word, with exactly one bit set in o_rom_addr during that cycle.
- Never more than one read outstanding.
- Timing with i_ready tied to 1 and READ_LAT=1:
  - i_start sampled high in cycle 0 -> o_rom_en in cycle 1.
  - Capture at the end of cycle 2; o_valid in cycle 3.
  - Word k: o_rom_en in cycle 1+3k, o_valid in cycle 3+3k.
  - Period is READ_LAT+2 cycles per word.
- i_start while busy is ignored with no side effects. i_start held high continuously re-triggers a run immediately after DONE, on the IDLE cycle.
- o_checksum holds its final value in IDLE until the next i_start or reset.
- i_rom_data is ignored outside the capture cycle.

Test Plan:
- ROM model contents {48,67,44,A3,BB,DE,AD,07}, i_ready=1, i_start pulse in cycle 0 -> expected response:
  - o_rom_addr sequence 01,02,04,...,80 in cycles 1,4,...,22.
  - Stream bytes 48,67,44,A3,BB,DE,AD,07 with o_valid in cycles 3..24.
  - o_done in cycle 25; o_checksum=E3; o_busy high in cycles 1..25.
- Backpressure: i_ready=0 for 5 cycles on word 2 -> o_data holds 44 with o_valid high; next o_rom_en (addr 08) occurs only in the cycle after the i_ready=1 handshake; final checksum still E3.
- i_start pulsed again mid-run (cycle 10) -> ignored; address sequence and byte stream identical to the first scenario.
- i_rst_n asserted in cycle 12 -> all outputs 0 immediately (asynchronous); after release and a new i_start, the run restarts at addr 01 with checksum restarting from 0.
- READ_LAT=3, NUM_WORDS=4 -> o_rom_en once per 5 cycles at addresses 01,02,04,08; bytes 48,67,44,A3; checksum F3+A3=96.
- Protocol checker, across all runs: o_rom_en never high for two consecutive cycles; o_rom_addr is always one-hot when enabled and 0 otherwise; o_data is unchanged while o_valid=1 and i_ready=0.
